// File: rtl/lc3_addr_ctl_pkg.sv
// Shared constants for the LC-3 address-control unit: device map, access FSM states, device select.
package lc3_addr_ctl_pkg;

   localparam int unsigned REG_W = 16;
   localparam int unsigned CNT_W = 4;

   localparam logic [REG_W-1:0] IO_BASE   = 16'hFE00;
   localparam logic [REG_W-1:0] KBSR_ADDR = 16'hFE00;
   localparam logic [REG_W-1:0] KBDR_ADDR = 16'hFE02;
   localparam logic [REG_W-1:0] DSR_ADDR  = 16'hFE04;
   localparam logic [REG_W-1:0] DDR_ADDR  = 16'hFE06;
   localparam logic [REG_W-1:0] MCR_ADDR  = 16'hFFFE;
   localparam logic [REG_W-1:0] MCR_RESET = 16'h8000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DONE     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      DEV_NONE = 3'd0,
      DEV_KBSR = 3'd1,
      DEV_KBDR = 3'd2,
      DEV_DSR  = 3'd3,
      DEV_DDR  = 3'd4,
      DEV_MCR  = 3'd5
   } dev_t;

   // Map an I/O-page address onto a device register; anything else is unmapped.
   function automatic dev_t dev_decode(input logic [REG_W-1:0] addr);
      case (addr)
         KBSR_ADDR: dev_decode = DEV_KBSR;
         KBDR_ADDR: dev_decode = DEV_KBDR;
         DSR_ADDR:  dev_decode = DEV_DSR;
         DDR_ADDR:  dev_decode = DEV_DDR;
         MCR_ADDR:  dev_decode = DEV_MCR;
         default:   dev_decode = DEV_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lc3_dev_regs.sv
// Memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR), keyboard/display handshakes and read mux.
// LC3_KB_IRQ_EN makes KBSR[14] writable and drives a registered keyboard interrupt.
module lc3_dev_regs
   import lc3_addr_ctl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             acc,
   input  logic             we,
   input  dev_t             sel,
   input  logic [REG_W-1:0] wdata,
   input  logic             kb_valid,
   input  logic [7:0]       kb_data,
   input  logic             disp_ready,
   output logic [REG_W-1:0] rdata_c,
   output logic             disp_valid,
   output logic [7:0]       disp_data,
   output logic             clk_en,
   output logic             kb_irq
);

   logic             kb_full;
   logic             kb_ie;
   logic             dsr_rdy;
   logic [7:0]       kbdr;
   logic [7:0]       ddr;
   logic [REG_W-1:0] mcr;
   logic             wr_c;
   logic             rd_c;

   assign wr_c = acc & we;
   assign rd_c = acc & ~we;

   // A new keystroke beats a simultaneous KBDR read clearing the ready flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kb_full <= 1'b0;
         kbdr    <= 8'h00;
      end else if (kb_valid) begin
         kb_full <= 1'b1;
         kbdr    <= kb_data;
      end else if (rd_c && sel == DEV_KBDR) begin
         kb_full <= 1'b0;
      end
   end

`ifdef LC3_KB_IRQ_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kb_ie  <= 1'b0;
         kb_irq <= 1'b0;
      end else begin
         if (wr_c && sel == DEV_KBSR) kb_ie <= wdata[14];
         kb_irq <= kb_full & kb_ie;
      end
   end
`else
   assign kb_ie  = 1'b0;
   assign kb_irq = 1'b0;
`endif

   // DDR only accepts a character while the display is idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dsr_rdy    <= 1'b1;
         ddr        <= 8'h00;
         disp_valid <= 1'b0;
      end else if (wr_c && sel == DEV_DDR && dsr_rdy) begin
         ddr        <= wdata[7:0];
         dsr_rdy    <= 1'b0;
         disp_valid <= 1'b1;
      end else if (disp_valid && disp_ready) begin
         disp_valid <= 1'b0;
         dsr_rdy    <= 1'b1;
      end
   end

   assign disp_data = ddr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcr <= MCR_RESET;
      end else if (wr_c && sel == DEV_MCR) begin
         mcr <= wdata;
      end
   end

   assign clk_en = mcr[15];

   always_comb begin
      rdata_c = '0;
      case (sel)
         DEV_KBSR: rdata_c = {kb_full, kb_ie, 14'd0};
         DEV_KBDR: rdata_c = {8'd0, kbdr};
         DEV_DSR:  rdata_c = {dsr_rdy, 15'd0};
         DEV_DDR:  rdata_c = {8'd0, ddr};
         DEV_MCR:  rdata_c = mcr;
         default:  rdata_c = '0;
      endcase
   end

endmodule

// File: rtl/lc3_addr_ctl.sv
// LC-3 address-control / memory-interface unit: access sequencer, wait counter and address decode.
// Optional keyboard interrupt (LC3_KB_IRQ_EN) lives in lc3_dev_regs.
module lc3_addr_ctl
   import lc3_addr_ctl_pkg::*;
#(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned MEM_LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mio_en,
   input  logic             r_w,
   input  logic [WIDTH-1:0] mar,
   input  logic [WIDTH-1:0] mdr,
   output logic             ready,
   output logic [WIDTH-1:0] rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             kb_valid,
   input  logic [7:0]       kb_data,
   output logic             disp_valid,
   output logic [7:0]       disp_data,
   input  logic             disp_ready,
   output logic             clk_en,
   output logic             kb_irq
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_d;
   logic             mem_en_d;
   logic             mem_we_d;
   logic             start_c;
   logic             capture_c;
   logic             dev_acc_c;
   logic             is_mem_c;
   logic [WIDTH-1:0] addr_q;
   logic [WIDTH-1:0] wdata_q;
   logic             wr_q;
   logic             is_mem_q;
   logic [REG_W-1:0] dev_rdata_c;
   dev_t             dev_sel_c;

   assign is_mem_c  = (mar < WIDTH'(IO_BASE));
   assign dev_sel_c = dev_decode(REG_W'(addr_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready   <= 1'b0;
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready   <= ready_d;
         mem_en  <= mem_en_d;
         mem_we  <= mem_we_d;
      end
   end

   // RELEASE waits for the request to drop so a held mio_en cannot start a second access.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_d   = 1'b0;
      mem_en_d  = 1'b0;
      mem_we_d  = 1'b0;
      start_c   = 1'b0;
      capture_c = 1'b0;
      dev_acc_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (mio_en) begin
               start_c = 1'b1;
               if (is_mem_c) begin
                  mem_en_d = 1'b1;
                  mem_we_d = r_w;
                  cnt_d    = CNT_W'(MEM_LATENCY - 1);
                  state_d  = MEM_WAIT;
               end else begin
                  state_d  = DONE;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt_q == '0) begin
               capture_c = ~wr_q;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            ready_d   = 1'b1;
            dev_acc_c = ~is_mem_q;
            state_d   = RELEASE;
         end
         RELEASE: begin
            if (!mio_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         is_mem_q  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         if (start_c) begin
            addr_q   <= mar;
            wdata_q  <= mdr;
            wr_q     <= r_w;
            is_mem_q <= is_mem_c;
            if (is_mem_c) begin
               mem_addr  <= mar;
               mem_wdata <= mdr;
            end
         end
         if (capture_c) begin
            rdata <= mem_rdata;
         end else if (dev_acc_c && !wr_q) begin
            rdata <= WIDTH'(dev_rdata_c);
         end
      end
   end

   lc3_dev_regs u_dev_regs (
      .clk        (clk),
      .reset      (reset),
      .acc        (dev_acc_c),
      .we         (wr_q),
      .sel        (dev_sel_c),
      .wdata      (REG_W'(wdata_q)),
      .kb_valid   (kb_valid),
      .kb_data    (kb_data),
      .disp_ready (disp_ready),
      .rdata_c    (dev_rdata_c),
      .disp_valid (disp_valid),
      .disp_data  (disp_data),
      .clk_en     (clk_en),
      .kb_irq     (kb_irq)
   );

endmodule
